// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit boundary: instruction-memory read handshake, branch redirect and the byte stream
// handed to decode. The master modport is the fetch unit's view.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic [ADDR_W-1:0] out_pc;
  logic              out_first;

  modport master (
    output mem_req, mem_addr, out_valid, out_byte, out_pc, out_first,
    input  mem_ack, mem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_byte, out_pc, out_first,
    output mem_ack, mem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one-byte reads, buffers bytes in a prefetch FIFO and
// tags each delivered byte as opcode or immediate. Redirects flush the FIFO and restart fetch.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Immediate count carried by an opcode (top three bits), saturated at 3.
  function automatic logic [1:0] imm_count(input logic [2:0] op_top);
    logic [1:0] n;
    if (op_top[2]) begin
      n = 2'd3;
    end else begin
      n = op_top[1:0];
    end
    return n;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [1:0]        imm_left_q, imm_left_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        fifo_byte_q [FIFO_DEPTH];
  logic [7:0]        fifo_byte_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc_d   [FIFO_DEPTH];

  logic              fifo_empty_s;
  logic [7:0]        head_byte_s;
  logic [ADDR_W-1:0] head_pc_s;
  logic              out_valid_s;
  logic              pop_s;
  logic              push_s;
  logic [CNT_W-1:0]  count_after_s;

  // Next-state for the fetch FSM, PC, FIFO and immediate tracking.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    imm_left_d   = imm_left_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fifo_byte_d  = fifo_byte_q;
    fifo_pc_d    = fifo_pc_q;

    fifo_empty_s  = (count_q == {CNT_W{1'b0}});
    head_byte_s   = fifo_byte_q[rd_ptr_q];
    head_pc_s     = fifo_pc_q[rd_ptr_q];
    out_valid_s   = !fifo_empty_s && !bus.redirect_valid;
    pop_s         = out_valid_s && bus.out_ready;
    push_s        = (state_q == ST_REQ) && bus.mem_ack && !bus.redirect_valid;
    count_after_s = count_q + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};

    // Issue only while a slot is free for the in-flight byte, so a push never overflows.
    case (state_q)
      ST_IDLE: begin
        if (!bus.redirect_valid && (count_q < DEPTH_C)) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.redirect_valid) begin
          state_d      = bus.mem_ack ? ST_IDLE : ST_DRAIN;
          drain_addr_d = pc_q;
        end else if (bus.mem_ack) begin
          state_d = (count_after_s < DEPTH_C) ? ST_REQ : ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (bus.mem_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_pc;
      imm_left_d = 2'd0;
      rd_ptr_d   = {PTR_W{1'b0}};
      wr_ptr_d   = {PTR_W{1'b0}};
      count_d    = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_byte_d[wr_ptr_q] = bus.mem_rdata;
        fifo_pc_d[wr_ptr_q]   = pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        pc_d                  = pc_q + ADDR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (imm_left_q == 2'd0) begin
          imm_left_d = imm_count(head_byte_s[7:5]);
        end else begin
          imm_left_d = imm_left_q - 2'd1;
        end
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_after_s;
    end
  end

  // State registers; async reset abandons any outstanding request at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      imm_left_q   <= 2'd0;
      rd_ptr_q     <= {PTR_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_byte_q[i] <= 8'h00;
        fifo_pc_q[i]   <= {ADDR_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      imm_left_q   <= imm_left_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fifo_byte_q  <= fifo_byte_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

  // DRAIN keeps presenting the abandoned address even though pc already moved on.
  assign bus.mem_req   = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign bus.mem_addr  = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign bus.out_valid = out_valid_s;
  assign bus.out_byte  = fifo_empty_s ? 8'h00 : head_byte_s;
  assign bus.out_pc    = fifo_empty_s ? {ADDR_W{1'b0}} : head_pc_s;
  assign bus.out_first = !fifo_empty_s && (imm_left_q == 2'd0);
endmodule
